// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between execute and memory.
// One bus transaction per op, with misalign and timeout errors.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] cnt_q;
  logic [16:0] cnt_inc;
  logic        tmo, accept, bad;
  logic        misalign, illegal;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext, lanes;
  logic [3:0]  wmask;
  logic        req, done, ok_load;

  assign ready_o = (state_q == S_IDLE);
  assign accept  = valid_i && ready_o;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign tmo     = cnt_inc >= 17'(TIMEOUT_CYCLES);
  assign bad     = misalign || illegal;

  // legality and alignment of the incoming op
  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    unique case (funct3_i)
      3'b000: misalign = 1'b0;
      3'b001: misalign = addr_i[0];
      3'b010: misalign = |addr_i[1:0];
      3'b100: illegal = is_store_i;
      3'b101: begin
        illegal  = is_store_i;
        misalign = addr_i[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign lb = 8'(mem_rdata_i >> {addr_q[1:0], 3'b000});
  assign lh = 16'(mem_rdata_i >> {addr_q[1], 4'b0000});

  // load result extraction and extension
  always_comb begin
    ext = mem_rdata_i;
    unique case (1'b1)
      f3_q == 3'b000: ext = {{24{lb[7]}}, lb};
      f3_q == 3'b001: ext = {{16{lh[15]}}, lh};
      f3_q == 3'b100: ext = {24'd0, lb};
      f3_q == 3'b101: ext = {16'd0, lh};
      default:        ext = mem_rdata_i;
    endcase
  end

  // store byte-lane steering
  always_comb begin
    wmask = 4'hf;
    lanes = wdata_q;
    unique case (1'b1)
      f3_q == 3'b000: begin
        wmask = 4'b0001 << addr_q[1:0];
        lanes = {4{wdata_q[7:0]}};
      end
      f3_q == 3'b001: begin
        wmask = addr_q[1] ? 4'b1100 : 4'b0011;
        lanes = {2{wdata_q[15:0]}};
      end
      default: wmask = 4'hf;
    endcase
  end

  // next state, error cause and load data
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = '0;
          cause_d = bad ? 2'b01 : 2'b00;
          state_d = bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i && store_q) begin
          state_d = S_DONE;
        end else if (tmo) begin
          cause_d = 2'b10;
          state_d = S_DONE;
        end else if (mem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = ext;
          state_d = S_DONE;
        end else if (tmo) begin
          cause_d = 2'b10;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, op latch and timeout counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      data_q  <= data_d;
      if (accept) begin
        store_q <= is_store_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        rd_q    <= rd_i;
        cnt_q   <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        cnt_q <= cnt_inc[15:0];
      end
    end
  end

  assign req     = (state_q == S_REQ);
  assign done    = (state_q == S_DONE);
  assign ok_load = done && !store_q && (cause_q == 2'b00);

  assign mem_req_o   = req;
  assign mem_we_o    = req && store_q;
  assign mem_addr_o  = req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata_o = (req && store_q) ? lanes : '0;
  assign mem_wmask_o = (req && store_q) ? wmask : '0;

  assign done_o      = done;
  assign err_o       = done && (cause_q != 2'b00);
  assign err_cause_o = done ? cause_q : 2'b00;
  assign err_addr_o  = err_o ? addr_q : '0;
  assign wb_we_o     = ok_load && (rd_q != 5'd0);
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = ok_load ? data_q : '0;

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: table vectors, corner sequences and random ops
// checked against a behavioural model of the load/store rules.
module tb_lsu_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  rd_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        done_o, wb_we_o, err_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o, err_addr_o;
  logic [1:0]  err_cause_o;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .valid_i(valid_i), .ready_o(ready_o),
    .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .done_o(done_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .err_o(err_o),
    .err_cause_o(err_cause_o), .err_addr_o(err_addr_o)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          g;
    int          r;
    logic [31:0] rdata;
    logic [1:0]  ec;
    logic [3:0]  em;
    logic [31:0] emw;
    logic [31:0] ewb;
  } vec_t;

  int nvec = 0;
  int nbad = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_ready"}, 32'(ready_o), 1);
    chk({p, "_req"}, 32'(mem_req_o), 0);
    chk({p, "_we"}, 32'(mem_we_o), 0);
    chk({p, "_addr"}, mem_addr_o, 0);
    chk({p, "_wdata"}, mem_wdata_o, 0);
    chk({p, "_mask"}, 32'(mem_wmask_o), 0);
    chk({p, "_done"}, 32'(done_o), 0);
    chk({p, "_wbwe"}, 32'(wb_we_o), 0);
    chk({p, "_wbrd"}, 32'(wb_rd_o), 0);
    chk({p, "_wbdata"}, wb_data_o, 0);
    chk({p, "_err"}, 32'(err_o), 0);
    chk({p, "_cause"}, 32'(err_cause_o), 0);
    chk({p, "_eaddr"}, err_addr_o, 0);
  endtask

  // Reference rules: size from funct3, alignment by modulo,
  // lanes and extension by plain arithmetic.
  function automatic void model(inout vec_t v);
    int unsigned sz, off;
    logic [31:0] s;
    logic legal;
    sz  = 1 << v.f3[1:0];
    off = v.a % 4;
    legal = (v.f3 == 0 || v.f3 == 1 || v.f3 == 2) ||
            (!v.st && (v.f3 == 4 || v.f3 == 5));
    v.ec = (!legal || (v.a % sz) != 0) ? 2'b01 : 2'b00;
    v.em = 4'(((1 << sz) - 1) << off);
    if (sz == 1) v.emw = v.wd[7:0] * 32'h01010101;
    else if (sz == 2) v.emw = v.wd[15:0] * 32'h00010001;
    else v.emw = v.wd;
    s = v.rdata >> (8 * off);
    if (sz == 1) begin
      v.ewb = s & 32'hff;
      if (!v.f3[2] && v.ewb >= 128) v.ewb = v.ewb - 256;
    end else if (sz == 2) begin
      v.ewb = s & 32'hffff;
      if (!v.f3[2] && v.ewb >= 32768) v.ewb = v.ewb - 65536;
    end else begin
      v.ewb = v.rdata;
    end
  endfunction

  // Called on a negedge with the unit idle; returns on the
  // negedge after completion, when the unit is idle again.
  task automatic run_op(input vec_t v);
    int c, kd, reqlast;
    logic [1:0] cause;
    logic ld_ok;
    if (v.ec == 2'b01) begin
      cause = 2'b01;
      kd = 1;
      reqlast = 0;
    end else begin
      c = v.st ? v.g + 1 : v.g + 2 + v.r;
      cause = (c <= TO) ? 2'b00 : 2'b10;
      kd = (c <= TO) ? c + 1 : TO + 1;
      reqlast = (v.g + 1 < TO) ? v.g + 1 : TO;
    end
    ld_ok = !v.st && cause == 2'b00;
    chk("idle_ready", 32'(ready_o), 1);
    chk("idle_done", 32'(done_o), 0);
    valid_i = 1'b1;
    is_store_i = v.st;
    funct3_i = v.f3;
    addr_i = v.a;
    wdata_i = v.wd;
    rd_i = v.rd;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'($urandom);
    for (int k = 1; k <= kd; k++) begin
      @(negedge clk);
      chk("busy_ready", 32'(ready_o), 0);
      chk("req", 32'(mem_req_o), 32'(k <= reqlast));
      if (k <= reqlast) begin
        chk("maddr", mem_addr_o, v.a & 32'hffff_fffc);
        chk("mwe", 32'(mem_we_o), 32'(v.st));
        if (v.st) begin
          chk("mmask", 32'(mem_wmask_o), 32'(v.em));
          chk("mwdata", mem_wdata_o, v.emw);
        end
      end
      chk("done", 32'(done_o), 32'(k == kd));
      if (k == kd) begin
        chk("err", 32'(err_o), 32'(cause != 0));
        chk("cause", 32'(err_cause_o), 32'(cause));
        chk("eaddr", err_addr_o, (cause != 0) ? v.a : 32'd0);
        chk("wbwe", 32'(wb_we_o), 32'(ld_ok && v.rd != 0));
        chk("wbdata", wb_data_o, ld_ok ? v.ewb : 32'd0);
        if (!v.st) chk("wbrd", 32'(wb_rd_o), 32'(v.rd));
        valid_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
      end else begin
        valid_i = 1'b1;
        is_store_i = 1'($urandom);
        funct3_i = 3'($urandom);
        addr_i = $urandom;
        wdata_i = $urandom;
        rd_i = 5'($urandom);
        mem_gnt_i = (k == v.g + 1) && (k <= reqlast);
        if (!v.st && k == v.g + 2 + v.r) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = v.rdata;
        end else begin
          mem_rvalid_i = (k <= v.g + 1) ? 1'($urandom) : 1'b0;
          mem_rdata_i = $urandom;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // st f3 addr wdata rd g r rdata ec mask mwdata wbdata
    tbl.push_back('{1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0, 0,
                    0, 4'hf, 32'hDEADBEEF, 0});
    tbl.push_back('{1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, 0,
                    0, 4'h8, 32'hA5A5A5A5, 0});
    tbl.push_back('{0, 3'b000, 32'h301, 0, 5, 0, 0, 32'h12348056,
                    0, 0, 0, 32'hFFFFFF80});
    tbl.push_back('{0, 3'b100, 32'h301, 0, 5, 0, 0, 32'h12348056,
                    0, 0, 0, 32'h00000080});
    tbl.push_back('{0, 3'b001, 32'h302, 0, 5, 0, 0, 32'h9ABC0000,
                    0, 0, 0, 32'hFFFF9ABC});
    tbl.push_back('{0, 3'b101, 32'h302, 0, 6, 1, 1, 32'h9ABC0000,
                    0, 0, 0, 32'h00009ABC});
    tbl.push_back('{0, 3'b010, 32'h402, 0, 3, 0, 0, 0,
                    1, 0, 0, 0});
    tbl.push_back('{1, 3'b001, 32'h202, 32'h1234BEEF, 0, 1, 0, 0,
                    0, 4'hc, 32'hBEEFBEEF, 0});
    tbl.push_back('{0, 3'b010, 32'h400, 0, 0, 0, 1, 32'hCAFEF00D,
                    0, 0, 0, 32'hCAFEF00D});
    tbl.push_back('{1, 3'b100, 32'h100, 32'h1, 0, 0, 0, 0,
                    1, 0, 0, 0});
    tbl.push_back('{0, 3'b001, 32'h301, 0, 4, 0, 0, 0,
                    1, 0, 0, 0});
    tbl.push_back('{0, 3'b011, 32'h300, 0, 4, 0, 0, 0,
                    1, 0, 0, 0});
    tbl.push_back('{1, 3'b010, 32'h108, 32'h11223344, 0, 3, 0, 0,
                    0, 4'hf, 32'h11223344, 0});
    tbl.push_back('{0, 3'b010, 32'h10C, 0, 9, 0, 2, 32'h55AA55AA,
                    0, 0, 0, 32'h55AA55AA});
    tbl.push_back('{0, 3'b010, 32'h10C, 0, 9, 0, 3, 32'h55AA55AA,
                    0, 0, 0, 32'h55AA55AA});
    tbl.push_back('{0, 3'b000, 32'h10C, 0, 9, 0, 99, 32'h1,
                    0, 0, 0, 32'h1});
    tbl.push_back('{1, 3'b010, 32'h110, 32'h77, 0, 99, 0, 0,
                    0, 4'hf, 32'h77, 0});
    tbl.push_back('{0, 3'b010, 32'h114, 0, 2, 3, 0, 32'h9,
                    0, 0, 0, 32'h9});

    repeat (2) @(negedge clk);
    chk_quiet("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_rst");

    foreach (tbl[i]) run_op(tbl[i]);

    // reset while waiting for read data
    valid_i = 1'b1;
    is_store_i = 1'b0;
    funct3_i = 3'b010;
    addr_i = 32'h500;
    rd_i = 5'd7;
    @(negedge clk);
    valid_i = 1'b0;
    chk("rw_req", 32'(mem_req_o), 1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("rw_wait_req", 32'(mem_req_o), 0);
    chk("rw_wait_ready", 32'(ready_o), 0);
    rst_n = 1'b0;
    #1;
    chk_quiet("rw_async");
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h12345678;
    @(negedge clk);
    rst_n = 1'b1;
    chk_quiet("rw_held");
    @(negedge clk);
    chk_quiet("rw_after");
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk_quiet("rw_idle");

    for (int n = 0; n < 250; n++) begin
      logic [2:0] f3s [5];
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      v.st = 1'($urandom);
      v.f3 = ($urandom % 8 == 0) ? 3'($urandom) : f3s[$urandom % 5];
      v.a = $urandom;
      if ($urandom % 4 != 0) v.a[1:0] = 2'b00;
      v.wd = $urandom;
      v.rd = 5'($urandom);
      v.g = $urandom % 5;
      v.r = $urandom % 4;
      v.rdata = $urandom;
      model(v);
      run_op(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
